bcd_countdown_timer: RTL and testbench

- Synchronous multi-digit BCD down-counter with load, start and pause control, plus terminal-count signalling.
- This is the count-down counterpart to the team's decade up-counters.
- Used as a preset interval timer: software or an FSM loads a decimal preset, and the block counts it to zero and reports completion.
- Fully synchronous single-clock design. No ripple clocking.

---
 rtl/bcd_countdown_timer.sv | 163 ++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//
// Multi-digit BCD down-counter used as a preset interval timer. A decimal
// preset is loaded, counting is started, and the block counts the value to
// zero and then reports completion with a one-cycle done pulse. With
// AUTO_RELOAD set, it reloads the preset on reaching zero and keeps running.
//
// Parameters:
//    DIGITS      - number of BCD digits (Q width = 4*DIGITS)
//    AUTO_RELOAD - 1: reload the preset at zero and keep running
//                  0: stop in DONE at zero
//
// Ports:
//    Clk        in   system clock, rising edge
//    clr        in   asynchronous active-low reset
//    load       in   synchronous preset strobe (wins over start and pause)
//    load_val   in   BCD preset; digits above 9 are clamped to 9
//    start      in   begin/resume counting, or restart from DONE
//    pause      in   hold the count while running
//    Q          out  current BCD count (registered)
//    tc         out  combinational, 1 when Q == 0
//    done       out  registered one-cycle completion pulse
//    busy       out  registered, 1 while in RUN
//    state_dbg  out  current FSM state (IDLE=0, RUN=1, PAUSED=2, DONE=3)
//
// Control semantics: load, start and pause are level-sampled strobes with no
// handshake. Each is acted on at every rising edge where it is high, with
// priority load > start > pause; no acknowledge is returned.
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
   parameter int DIGITS      = 2,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic                  Clk,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  tc,
   output logic                  done,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   q_n;
   logic [W-1:0]   preset, preset_n;
   logic           done_n;
   logic           busy_n;
   logic           q_zero;
   logic [W-1:0]   load_clamped;
   logic [W-1:0]   q_dec;

   // Force every digit into 0..9 so a non-BCD value can never enter Q or
   // the preset register.
   function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      end
      return r;
   endfunction

   // BCD decrement by one: a digit at 0 wraps to 9 and passes the borrow up.
   // Only used when the value is non-zero, so the chain never wraps fully.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      logic [3:0]   d;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = d - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign q_zero       = (Q == '0);
   assign tc           = q_zero;
   assign load_clamped = clamp_bcd(load_val);
   assign q_dec        = bcd_dec(Q);
   assign state_dbg    = state;

   // -------------------------------------------------------------------
   // Next-state / next-count logic
   // -------------------------------------------------------------------
   always_comb begin
      state_n  = state;
      q_n      = Q;
      preset_n = preset;
      done_n   = 1'b0;

      if (load) begin
         q_n      = load_clamped;
         preset_n = load_clamped;
         state_n  = S_IDLE;
      end else if (start && (state != S_RUN)) begin
         // Entering RUN leaves Q alone; the first decrement happens on the
         // following edge. Restarting from DONE reloads the preset first.
         if (state == S_DONE) begin
            q_n = preset;
         end
         state_n = S_RUN;
      end else if (pause && !start && (state == S_RUN)) begin
         state_n = S_PAUSED;
      end else if (state == S_RUN) begin
         // start held high while already running does not block counting.
         if (!q_zero) begin
            q_n = q_dec;
         end else begin
            done_n = 1'b1;
            if (AUTO_RELOAD) begin
               q_n = preset;
            end else begin
               state_n = S_DONE;
            end
         end
      end

      busy_n = (state_n == S_RUN);
   end

   // -------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------
   always_ff @(posedge Clk or negedge clr) begin
      if (!clr) begin
         state  <= S_IDLE;
         Q      <= '0;
         preset <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         Q      <= q_n;
         preset <= preset_n;
         done   <= done_n;
         busy   <= busy_n;
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

   // ---------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------
   logic clk;
   logic clr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DUT with DIGITS=2, AUTO_RELOAD=0
   logic        ld2, st2, pa2;
   logic [7:0]  lv2;
   logic [7:0]  q2;
   logic        tc2, dn2, bz2;
   logic [1:0]  sd2;

   // DUT with DIGITS=3, AUTO_RELOAD=0
   logic        ld3, st3, pa3;
   logic [11:0] lv3;
   logic [11:0] q3;
   logic        tc3, dn3, bz3;
   logic [1:0]  sd3;

   // DUT with DIGITS=2, AUTO_RELOAD=1
   logic        lda, sta, paa;
   logic [7:0]  lva;
   logic [7:0]  qa;
   logic        tca, dna, bza;
   logic [1:0]  sda;

   int n_cmp;
   int n_fail;

   logic [7:0] exp_q[$];

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut2 (
      .Clk(clk), .clr(clr), .load(ld2), .load_val(lv2), .start(st2),
      .pause(pa2), .Q(q2), .tc(tc2), .done(dn2), .busy(bz2), .state_dbg(sd2)
   );

   bcd_countdown_timer #(.DIGITS(3), .AUTO_RELOAD(1'b0)) dut3 (
      .Clk(clk), .clr(clr), .load(ld3), .load_val(lv3), .start(st3),
      .pause(pa3), .Q(q3), .tc(tc3), .done(dn3), .busy(bz3), .state_dbg(sd3)
   );

   bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) duta (
      .Clk(clk), .clr(clr), .load(lda), .load_val(lva), .start(sta),
      .pause(paa), .Q(qa), .tc(tca), .done(dna), .busy(bza), .state_dbg(sda)
   );

   // ---------------------------------------------------------------
   // Driver tasks: inputs change 1 time unit after a rising edge,
   // outputs are sampled at the same point (away from the edge).
   // ---------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ld2 = 0; st2 = 0; pa2 = 0; lv2 = '0;
      ld3 = 0; st3 = 0; pa3 = 0; lv3 = '0;
      lda = 0; sta = 0; paa = 0; lva = '0;
   endtask

   function automatic logic [7:0] to_bcd2(input int k);
      logic [3:0] hi, lo;
      hi = 4'(k / 10);
      lo = 4'(k % 10);
      return {hi, lo};
   endfunction

   // ---------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------
   task automatic test_reset();
      // Get a non-zero count in first so the async clear is visible.
      ld2 = 1; lv2 = 8'h34; step(); ld2 = 0;
      n_cmp++;
      if (q2 !== 8'h34) begin n_fail++; $display("FAIL reset_preload: Q=%h want 34", q2); end

      st2 = 1; step(); st2 = 0; step();
      // Mid-cycle async clear: no clock edge between assert and check.
      #2 clr = 0; #1;
      n_cmp++;
      if (q2 !== 8'h00) begin n_fail++; $display("FAIL reset_q: Q=%h want 00", q2); end
      n_cmp++;
      if (dn2 !== 1'b0 || bz2 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: done=%b busy=%b want 0 0", dn2, bz2); end
      n_cmp++;
      if (tc2 !== 1'b1) begin n_fail++; $display("FAIL reset_tc: tc=%b want 1", tc2); end
      n_cmp++;
      if (sd2 !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: state=%0d want 0", sd2); end

      #1 clr = 1;
      for (int i = 0; i < 3; i++) step();
      n_cmp++;
      if (q2 !== 8'h00 || dn2 !== 1'b0 || bz2 !== 1'b0 || tc2 !== 1'b1 || sd2 !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_hold: Q=%h done=%b busy=%b tc=%b state=%0d want 00 0 0 1 0", q2, dn2, bz2, tc2, sd2);
      end
   endtask

   task automatic test_basic_countdown();
      logic [7:0] e;
      ld2 = 1; lv2 = 8'h12; step(); ld2 = 0;
      st2 = 1; step(); st2 = 0;
      n_cmp++;
      if (q2 !== 8'h12 || bz2 !== 1'b1) begin n_fail++; $display("FAIL basic_start: Q=%h busy=%b want 12 1", q2, bz2); end

      for (int k = 11; k >= 0; k--) exp_q.push_back(to_bcd2(k));
      while (exp_q.size() > 0) begin
         step();
         e = exp_q.pop_front();
         n_cmp++;
         if (q2 !== e || dn2 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_seq: Q=%h done=%b want %h 0", q2, dn2, e);
         end
      end
      // 13th edge after start: terminal edge.
      step();
      n_cmp++;
      if (dn2 !== 1'b1 || bz2 !== 1'b0 || q2 !== 8'h00 || sd2 !== ST_DONE) begin
         n_fail++;
         $display("FAIL basic_done: done=%b busy=%b Q=%h state=%0d want 1 0 00 3", dn2, bz2, q2, sd2);
      end
      step();
      n_cmp++;
      if (dn2 !== 1'b0 || q2 !== 8'h00 || sd2 !== ST_DONE || tc2 !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_after: done=%b Q=%h state=%0d tc=%b want 0 00 3 1", dn2, q2, sd2, tc2);
      end
   endtask

   task automatic test_borrow_clamp();
      ld3 = 1; lv3 = 12'h100; step(); ld3 = 0;
      st3 = 1; step(); st3 = 0;
      step();
      n_cmp++;
      if (q3 !== 12'h099) begin n_fail++; $display("FAIL borrow_100: Q=%h want 099", q3); end
      step();
      n_cmp++;
      if (q3 !== 12'h098) begin n_fail++; $display("FAIL borrow_099: Q=%h want 098", q3); end

      ld2 = 1; lv2 = 8'hA5; step(); ld2 = 0;
      n_cmp++;
      if (q2 !== 8'h95 || sd2 !== ST_IDLE) begin n_fail++; $display("FAIL clamp_a5: Q=%h state=%0d want 95 0", q2, sd2); end
      ld2 = 1; lv2 = 8'hFC; step(); ld2 = 0;
      n_cmp++;
      if (q2 !== 8'h99) begin n_fail++; $display("FAIL clamp_fc: Q=%h want 99", q2); end
   endtask

   task automatic test_pause_resume();
      ld2 = 1; lv2 = 8'h05; step(); ld2 = 0;
      st2 = 1; step(); st2 = 0;
      step(); step();
      n_cmp++;
      if (q2 !== 8'h03) begin n_fail++; $display("FAIL pause_reach: Q=%h want 03", q2); end
      pa2 = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (q2 !== 8'h03 || bz2 !== 1'b0 || sd2 !== ST_PAUSED) begin
            n_fail++;
            $display("FAIL pause_hold: Q=%h busy=%b state=%0d want 03 0 2", q2, bz2, sd2);
         end
      end
      pa2 = 0;
      st2 = 1; step(); st2 = 0;
      n_cmp++;
      if (q2 !== 8'h03 || bz2 !== 1'b1) begin n_fail++; $display("FAIL resume: Q=%h busy=%b want 03 1", q2, bz2); end
      step();
      n_cmp++;
      if (q2 !== 8'h02) begin n_fail++; $display("FAIL resume_02: Q=%h want 02", q2); end
      step(); step();
      n_cmp++;
      if (q2 !== 8'h00 || dn2 !== 1'b0) begin n_fail++; $display("FAIL resume_00: Q=%h done=%b want 00 0", q2, dn2); end
      step();
      n_cmp++;
      if (dn2 !== 1'b1) begin n_fail++; $display("FAIL resume_done: done=%b want 1", dn2); end
   endtask

   task automatic test_priority();
      ld2 = 1; st2 = 1; lv2 = 8'h07; step(); ld2 = 0; st2 = 0;
      n_cmp++;
      if (q2 !== 8'h07 || sd2 !== ST_IDLE || bz2 !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_load_start: Q=%h state=%0d busy=%b want 07 0 0", q2, sd2, bz2);
      end
      st2 = 1; step(); st2 = 0;
      pa2 = 1; step(); pa2 = 0;
      n_cmp++;
      if (sd2 !== ST_PAUSED || q2 !== 8'h07) begin n_fail++; $display("FAIL prio_pause: state=%0d Q=%h want 2 07", sd2, q2); end
      st2 = 1; pa2 = 1; step(); st2 = 0; pa2 = 0;
      n_cmp++;
      if (sd2 !== ST_RUN || bz2 !== 1'b1 || q2 !== 8'h07) begin
         n_fail++;
         $display("FAIL prio_start_pause: state=%0d busy=%b Q=%h want 1 1 07", sd2, bz2, q2);
      end
      for (int i = 0; i < 8; i++) step();
      n_cmp++;
      if (dn2 !== 1'b1 || sd2 !== ST_DONE) begin n_fail++; $display("FAIL prio_done: done=%b state=%0d want 1 3", dn2, sd2); end
      st2 = 1; step(); st2 = 0;
      n_cmp++;
      if (q2 !== 8'h07 || bz2 !== 1'b1 || dn2 !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_reload: Q=%h busy=%b done=%b want 07 1 0", q2, bz2, dn2);
      end
      step();
      n_cmp++;
      if (q2 !== 8'h06) begin n_fail++; $display("FAIL restart_count: Q=%h want 06", q2); end
      // Load on the terminal edge wins and suppresses done.
      ld2 = 1; lv2 = 8'h01; step(); ld2 = 0;
      st2 = 1; step(); st2 = 0;
      step();
      ld2 = 1; lv2 = 8'h04; step(); ld2 = 0;
      n_cmp++;
      if (dn2 !== 1'b0 || q2 !== 8'h04 || sd2 !== ST_IDLE) begin
         n_fail++;
         $display("FAIL load_on_terminal: done=%b Q=%h state=%0d want 0 04 0", dn2, q2, sd2);
      end
   endtask

   task automatic test_auto_reload();
      logic [7:0] eq [6];
      logic       ed [6];
      eq = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
      ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      lda = 1; lva = 8'h02; step(); lda = 0;
      sta = 1; step(); sta = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         n_cmp++;
         if (qa !== eq[i] || dna !== ed[i] || bza !== 1'b1) begin
            n_fail++;
            $display("FAIL autoreload_%0d: Q=%h done=%b busy=%b want %h %b 1", i, qa, dna, bza, eq[i], ed[i]);
         end
      end
      lda = 1; lva = 8'h00; step(); lda = 0;
      sta = 1; step(); sta = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (dna !== 1'b1 || qa !== 8'h00 || bza !== 1'b1) begin
            n_fail++;
            $display("FAIL autoreload_zero_%0d: done=%b Q=%h busy=%b want 1 00 1", i, dna, qa, bza);
         end
      end
   endtask

   task automatic test_reset_abort();
      ld2 = 1; lv2 = 8'h01; step(); ld2 = 0;
      st2 = 1; step(); st2 = 0;
      step();
      // Q is 00; the next edge would raise done. Clear before it.
      #2 clr = 0;
      step();
      n_cmp++;
      if (dn2 !== 1'b0 || bz2 !== 1'b0 || sd2 !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_abort: done=%b busy=%b state=%0d want 0 0 0", dn2, bz2, sd2);
      end
      clr = 1;
      step();
      n_cmp++;
      if (dn2 !== 1'b0) begin n_fail++; $display("FAIL reset_abort_after: done=%b want 0", dn2); end
   endtask

   // ---------------------------------------------------------------
   // Sequence and final report
   // ---------------------------------------------------------------
   initial begin
      n_cmp  = 0;
      n_fail = 0;
      idle_inputs();
      clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b1;

      test_reset();
      test_basic_countdown();
      test_borrow_clamp();
      test_pause_resume();
      test_priority();
      test_auto_reload();
      test_reset_abort();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
